// File: rtl/countdown_pkg.sv
// Shared definitions for the loadable countdown timer: state encoding and default width.
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, pause, abort and a one-cycle expiry strobe.
// Optional macro COUNTDOWN_AUTORELOAD_EN adds a `reload` input that restarts from the last load.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
`ifdef COUNTDOWN_AUTORELOAD_EN
    input  logic             reload,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire
);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic             busy_reg;
    logic             expire_reg;
    logic             handshake;
    logic             terminal;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_reg;
`endif

    assign load_ready = (state_reg == ST_IDLE);
    assign handshake  = load_valid & load_ready;
    // Treating anything <= 1 as terminal keeps the decrement from ever wrapping below zero.
    assign terminal   = (count_reg <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            expire_reg <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            expire_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                        reload_reg <= load_value;
`endif
                        if (load_value != '0) begin
                            count_reg <= load_value;
                            busy_reg  <= 1'b1;
                            state_reg <= ST_RUN;
                        end else begin
                            // Zero-length timeout: expire immediately without leaving IDLE.
                            expire_reg <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (!pause) begin
                        if (terminal) begin
                            expire_reg <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            if (reload) begin
                                count_reg <= reload_reg;
                            end else begin
                                count_reg <= '0;
                                busy_reg  <= 1'b0;
                                state_reg <= ST_IDLE;
                            end
`else
                            count_reg <= '0;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
`endif
                        end else begin
                            count_reg <= count_reg - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign count  = count_reg;
    assign busy   = busy_reg;
    assign expire = expire_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a randomized run
// against a progress-based reference model. Define COUNTDOWN_AUTORELOAD_EN to cover reload.
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_value = '0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         reload = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         expire;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .pause      (pause),
        .abort      (abort),
`ifdef COUNTDOWN_AUTORELOAD_EN
        .reload     (reload),
`endif
        .count      (count),
        .busy       (busy),
        .expire     (expire)
    );

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (count !== '0)       begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (expire !== 1'b0)    begin errors++; $display("FAIL reset_expire: got %0b expected 0", expire); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", load_ready); end
        rst = 1'b0;
        load_valid = 1'b1; load_value = 9;
        step();
        load_valid = 1'b0;
        step();
        step();
        checks++; if (count !== W'(7)) begin errors++; $display("FAIL reset_precount: got %0d expected 7", count); end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (count !== '0)        begin errors++; $display("FAIL reset_mid_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_mid_busy: got %0b expected 0", busy); end
        checks++; if (expire !== 1'b0)     begin errors++; $display("FAIL reset_mid_expire: got %0b expected 0", expire); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %0b expected 1", load_ready); end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (expire !== 1'b0) begin errors++; $display("FAIL reset_no_expire: got %0b expected 0 at step %0d", expire, i); end
        end
        $display("test_reset: reset during count of 9 discarded");
    endtask

    task automatic test_basic();
        load_valid = 1'b1; load_value = 5;
        step();
        load_valid = 1'b0;
        checks++; if (count !== W'(5))     begin errors++; $display("FAIL basic_load_count: got %0d expected 5", count); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL basic_load_busy: got %0b expected 1", busy); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL basic_load_ready: got %0b expected 0", load_ready); end
        for (int k = 4; k >= 0; k--) begin
            step();
            checks++; if (count !== W'(k))              begin errors++; $display("FAIL basic_count: got %0d expected %0d", count, k); end
            checks++; if (expire !== 1'(k == 0))        begin errors++; $display("FAIL basic_expire: got %0b expected %0b at count %0d", expire, k == 0, k); end
            checks++; if (busy !== 1'(k != 0))          begin errors++; $display("FAIL basic_busy: got %0b expected %0b at count %0d", busy, k != 0, k); end
            checks++; if (load_ready !== 1'(k == 0))    begin errors++; $display("FAIL basic_ready: got %0b expected %0b at count %0d", load_ready, k == 0, k); end
        end
        step();
        checks++; if (expire !== 1'b0) begin errors++; $display("FAIL basic_expire_width: got %0b expected 0", expire); end
        $display("test_basic: load 5 expired after 5 edges");
    endtask

    task automatic test_pause();
        int t0;
        load_valid = 1'b1; load_value = 5;
        step();
        load_valid = 1'b0;
        t0 = cyc;
        step();
        step();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (count !== W'(3)) begin errors++; $display("FAIL pause_hold3: got %0d expected 3", count); end
            checks++; if (expire !== 1'b0) begin errors++; $display("FAIL pause_expire3: got %0b expected 0", expire); end
        end
        pause = 1'b0;
        step();
        step();
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (count !== W'(1)) begin errors++; $display("FAIL pause_hold1: got %0d expected 1", count); end
            checks++; if (expire !== 1'b0) begin errors++; $display("FAIL pause_expire1: got %0b expected 0", expire); end
            checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL pause_busy1: got %0b expected 1", busy); end
        end
        pause = 1'b0;
        step();
        checks++; if (expire !== 1'b1)   begin errors++; $display("FAIL pause_expire: got %0b expected 1", expire); end
        checks++; if (count !== '0)      begin errors++; $display("FAIL pause_final_count: got %0d expected 0", count); end
        checks++; if (cyc - t0 !== 10)   begin errors++; $display("FAIL pause_latency: got %0d expected 10", cyc - t0); end
        step();
        $display("test_pause: load 5 with 5 paused cycles expired after 10 edges");
    endtask

    task automatic test_abort();
        load_valid = 1'b1; load_value = 10;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (count !== W'(4)) begin errors++; $display("FAIL abort_precount: got %0d expected 4", count); end
        abort = 1'b1; pause = 1'b1;
        step();
        abort = 1'b0; pause = 1'b0;
        checks++; if (count !== '0)        begin errors++; $display("FAIL abort_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (expire !== 1'b0)     begin errors++; $display("FAIL abort_expire: got %0b expected 0", expire); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0b expected 1", load_ready); end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (expire !== 1'b0 || count !== '0) begin errors++; $display("FAIL abort_quiet: got expire %0b count %0d expected 0 0", expire, count); end
        end
        // Abort must beat the terminal decrement.
        load_valid = 1'b1; load_value = 2;
        step();
        load_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (expire !== 1'b0 || count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_terminal: got expire %0b count %0d busy %0b expected 0 0 0", expire, count, busy); end
        step();
        checks++; if (expire !== 1'b0) begin errors++; $display("FAIL abort_terminal_late: got %0b expected 0", expire); end
        // Abort in IDLE does not block a simultaneous load.
        load_valid = 1'b1; load_value = 3; abort = 1'b1;
        step();
        load_valid = 1'b0; abort = 1'b0;
        checks++; if (count !== W'(3) || busy !== 1'b1) begin errors++; $display("FAIL abort_idle_load: got count %0d busy %0b expected 3 1", count, busy); end
        step();
        step();
        step();
        checks++; if (expire !== 1'b1) begin errors++; $display("FAIL abort_idle_expire: got %0b expected 1", expire); end
        step();
        $display("test_abort: abort at 4, abort at 1, abort with idle load");
    endtask

    task automatic test_ignored_load();
        int t0;
        load_valid = 1'b1; load_value = 10;
        step();
        t0 = cyc;
        load_valid = 1'b0;
        step();
        load_valid = 1'b1; load_value = 7;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (count !== W'(8 - i)) begin errors++; $display("FAIL ignored_count: got %0d expected %0d", count, 8 - i); end
            checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ignored_ready: got %0b expected 0", load_ready); end
        end
        load_valid = 1'b0;
        for (int i = 0; i < 30 && expire !== 1'b1; i++) step();
        checks++; if (expire !== 1'b1)  begin errors++; $display("FAIL ignored_expire: got %0b expected 1 within budget", expire); end
        checks++; if (cyc - t0 !== 10) begin errors++; $display("FAIL ignored_latency: got %0d expected 10", cyc - t0); end
        step();
        $display("test_ignored_load: load 10 unaffected by mid-run load 7");
    endtask

    task automatic test_back_to_back();
        load_valid = 1'b1; load_value = 0;
        step();
        checks++; if (expire !== 1'b1)     begin errors++; $display("FAIL zero_expire: got %0b expected 1", expire); end
        checks++; if (count !== '0)        begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL zero_busy: got %0b expected 0", busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b expected 1", load_ready); end
        load_value = 3;
        step();
        load_valid = 1'b0;
        checks++; if (count !== W'(3) || busy !== 1'b1) begin errors++; $display("FAIL b2b_load: got count %0d busy %0b expected 3 1", count, busy); end
        checks++; if (expire !== 1'b0) begin errors++; $display("FAIL b2b_expire_drop: got %0b expected 0", expire); end
        step();
        step();
        checks++; if (expire !== 1'b0) begin errors++; $display("FAIL b2b_early: got %0b expected 0", expire); end
        step();
        checks++; if (expire !== 1'b1 || count !== '0) begin errors++; $display("FAIL b2b_expire: got expire %0b count %0d expected 1 0", expire, count); end
        step();
        $display("test_back_to_back: zero load then load 3 in the expire cycle");
    endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
    task automatic test_autoreload();
        int seq[12] = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 0};
        reload = 1'b1;
        load_valid = 1'b1; load_value = 4;
        step();
        load_valid = 1'b0;
        checks++; if (count !== W'(4)) begin errors++; $display("FAIL reload_load: got %0d expected 4", count); end
        for (int i = 0; i < 12; i++) begin
            if (i == 8) reload = 1'b0;
            step();
            checks++; if (count !== W'(seq[i]))                          begin errors++; $display("FAIL reload_count: got %0d expected %0d", count, seq[i]); end
            checks++; if (expire !== 1'(seq[i] == 4 || seq[i] == 0))     begin errors++; $display("FAIL reload_expire: got %0b at step %0d", expire, i); end
            checks++; if (busy !== 1'(seq[i] != 0))                      begin errors++; $display("FAIL reload_busy: got %0b at step %0d", busy, i); end
        end
        step();
        $display("test_autoreload: load 4 reloaded twice then stopped");
    endtask
`endif

    // Reference model: a countdown is "remaining = length - unpaused edges consumed".
    task automatic test_random();
        bit m_active = 0;
        int m_len = 0;
        int m_done = 0;
        bit exp_expire;
        int exp_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            load_valid = ($urandom_range(0, 2) == 0);
            load_value = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 63)) : W'($urandom_range(0, 8));
            pause      = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 24) == 0);
            exp_expire = 0;
            if (!m_active) begin
                if (load_valid) begin
                    $display("random: load %0d accepted at cycle %0d", load_value, cyc);
                    if (load_value == 0) exp_expire = 1;
                    else begin m_active = 1; m_len = int'(load_value); m_done = 0; end
                end
            end else if (abort) begin
                m_active = 0;
            end else if (!pause) begin
                m_done++;
                if (m_done == m_len) begin m_active = 0; exp_expire = 1; end
            end
            exp_count = m_active ? (m_len - m_done) : 0;
            step();
            checks++; if (count !== W'(exp_count))   begin errors++; $display("FAIL rand_count: got %0d expected %0d at cycle %0d", count, exp_count, cyc); end
            checks++; if (expire !== exp_expire)     begin errors++; $display("FAIL rand_expire: got %0b expected %0b at cycle %0d", expire, exp_expire, cyc); end
            checks++; if (busy !== m_active)         begin errors++; $display("FAIL rand_busy: got %0b expected %0b at cycle %0d", busy, m_active, cyc); end
            checks++; if (load_ready !== !m_active)  begin errors++; $display("FAIL rand_ready: got %0b expected %0b at cycle %0d", load_ready, !m_active, cyc); end
        end
        load_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_ignored_load();
        test_back_to_back();
`ifdef COUNTDOWN_AUTORELOAD_EN
        test_autoreload();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: accepts a start value over a valid/ready load handshake, counts down to zero once per enabled clock, then pulses an expiry strobe.
- The counterpart to the free-running up counter: a consumer issues timeouts and delays to it, instead of watching an up-count reach a target.
- Single clock domain.

Parameters:
- WIDTH, 6, bit width of the load value and the count (max load 2^WIDTH-1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  load request; load_value is valid.
- load_ready  output  1  block can accept a load (high only in IDLE).
- load_value  input  WIDTH  start value for the countdown.
- pause  input  1  freezes count while in RUN.
- abort  input  1  cancels an active countdown.
- count  output  WIDTH  current remaining count (registered).
- busy  output  1  high while in RUN.
- expire  output  1  one-cycle strobe when the count reaches zero.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered except load_ready, which is decoded from state.
- Reset: state=IDLE, count=0, busy=0, expire=0, load_ready=1. Reset mid-countdown discards the countdown with no expire.
- States are IDLE and RUN.
- IDLE:
  - load_ready=1. Handshake = load_valid & load_ready at a rising edge.
  - On handshake with load_value!=0: count<=load_value, go to RUN, busy<=1.
  - On handshake with load_value==0: stay IDLE, count stays 0, expire<=1 for one cycle (zero-length timeout).
  - abort in IDLE: no effect; a load in the same cycle is still accepted.
- RUN:
  - load_ready=0; load_valid is ignored and not queued.
  - Each edge with pause=0 and abort=0: count<=count-1.
  - When count==1 and pause=0: count<=0, expire<=1, busy<=0, go to IDLE.
  - pause=1: count holds; expire is not generated while paused, even at count==1.
  - abort=1: count<=0, busy<=0, go to IDLE, no expire. abort has priority over pause and over the terminal decrement.
- Latency: with handshake at edge E0 and load N>0, count=N after E0. With pause held low, count=0 and expire=1 in the cycle after edge E0+N. Each paused cycle adds one cycle.
- expire is high for exactly one cycle per completed countdown, never two consecutive cycles from one load.
- A new load is accepted no earlier than the cycle in which expire is high (load_ready=1 then); back-to-back timeouts are allowed.
- No arithmetic wrap: count never decrements below 0.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - Adds input `reload` (1 bit).
  - load_value is latched into reload_reg on every accepted load.
  - At terminal count in RUN with reload=1: expire<=1, count<=reload_reg, stay in RUN with busy=1; count does not show 0.
  - With reload=0, behaviour is as without the macro.
  - abort still ends the countdown. A reload_reg of 0 is impossible in RUN.
- Undefined: no `reload` port, no reload_reg, behaviour exactly as in Behaviour.

Decomposition:
- Package countdown_pkg: state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1, plus the default width constant (6).
- No sub-module: a single flat module; the datapath is one decrementer and one compare.

Test Plan:
- Reset: hold rst=1 for 2 cycles during an active count of 9 -> count=0, busy=0, expire=0, load_ready=1 the cycle after release; no expire ever fires.
- Basic timeout: load 5 at edge E0 -> count reads 5,4,3,2,1,0 after E0..E5; expire=1 only after E5; busy falls with it; load_ready=1 after E5.
- Pause: load 5, assert pause for 3 cycles at count=3 -> count holds 3; expire appears 3 cycles later than the basic case; no expire while paused at count=1.
- Abort and ignored load: load 10, assert abort at count=4 -> count=0, busy=0, expire never asserted. Separately, load 10 and assert load_valid with 7 mid-run -> ignored; 10-cycle expiry unchanged.
- Zero load and back-to-back: load 0 -> expire next cycle, count 0, busy 0. Load 3 immediately in the expire cycle -> accepted; second expire 3 cycles later.
- Autoreload (macro defined): load 4, reload=1 -> expire every 4 cycles; count cycles 4,3,2,1,4,3,…; dropping reload stops after the next expire with count=0.
